// File: rtl/inst_mem_responder_if.sv
// rtl/inst_mem_responder_if.sv - instruction-fetch request/response channel bundle
interface inst_mem_responder_if;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;

    modport master (
        output PC,
        output Inst_Req_Valid,
        output Inst_Ready,
        input  Inst_Req_Ready,
        input  Instruction,
        input  Inst_Valid
    );

    modport slave (
        input  PC,
        input  Inst_Req_Valid,
        input  Inst_Ready,
        output Inst_Req_Ready,
        output Instruction,
        output Inst_Valid
    );
endinterface

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - single-outstanding instruction fetch responder with load port
// Optional response-latency jitter: INST_RESP_JITTER_EN.
module inst_mem_responder #(
    parameter int ADDR_W   = 10,
    parameter int REQ_LAT  = 1,
    parameter int RESP_LAT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    inst_mem_responder_if.slave  bus,
    input  logic                 ld_we,
    input  logic [ADDR_W-1:0]    ld_addr,
    input  logic [31:0]          ld_data
);
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        BUSY = 3'b010,
        RESP = 3'b100
    } state_t;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic [4:0]        lat_cnt, lat_cnt_nxt;
    logic [4:0]        lat_load;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_en;
    logic              handshake;
    logic [31:0]       instr_q;
    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    // Byte offset and bits above the array size are dropped: misaligned PCs read the containing word.
    assign pc_addr = bus.PC[ADDR_W+1:2];
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.PC[31:ADDR_W+2], bus.PC[1:0]};

`ifdef INST_RESP_JITTER_EN
    logic [7:0] lfsr;
    always_ff @(posedge clk) begin
        if (rst) lfsr <= 8'hA5;
        else     lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign lat_load = 5'(RESP_LAT - 1) + {3'b000, lfsr[1:0]};
`else
    assign lat_load = 5'(RESP_LAT - 1);
`endif

    assign bus.Inst_Req_Ready = (state == IDLE) && (wait_cnt >= 4'(REQ_LAT));
    assign bus.Inst_Valid     = (state == RESP);
    assign bus.Instruction    = instr_q;
    assign handshake          = bus.Inst_Req_Ready && bus.Inst_Req_Valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            lat_cnt  <= 5'd0;
            addr     <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            lat_cnt  <= lat_cnt_nxt;
            addr     <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        lat_cnt_nxt  = lat_cnt;
        addr_nxt     = addr;
        rd_en        = 1'b0;
        rd_addr      = addr;
        case (state)
            IDLE: begin
                if (!bus.Inst_Req_Valid) begin
                    wait_cnt_nxt = 4'd0;
                end else if (handshake) begin
                    wait_cnt_nxt = 4'd0;
                    addr_nxt     = pc_addr;
                    // A one-cycle latency reads straight from the request, skipping BUSY.
                    if (lat_load == 5'd0) begin
                        rd_en     = 1'b1;
                        rd_addr   = pc_addr;
                        state_nxt = RESP;
                    end else begin
                        lat_cnt_nxt = lat_load - 5'd1;
                        state_nxt   = BUSY;
                    end
                end else if (wait_cnt != 4'd15) begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            BUSY: begin
                if (lat_cnt == 5'd0) begin
                    rd_en     = 1'b1;
                    state_nxt = RESP;
                end else begin
                    lat_cnt_nxt = lat_cnt - 5'd1;
                end
            end
            RESP: begin
                if (bus.Inst_Ready) begin
                    wait_cnt_nxt = 4'd0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Load port is independent of reset; a same-edge write leaves the read seeing old data.
    always_ff @(posedge clk) begin
        if (ld_we) mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (rst)        instr_q <= 32'd0;
        else if (rd_en) instr_q <= mem[rd_addr];
    end
endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - directed and table-driven checks for inst_mem_responder
module tb_inst_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        ld_we;
    logic [9:0]  ld_addr;
    logic [31:0] ld_data;

    always #5 clk = ~clk;

    inst_mem_responder_if a ();
    inst_mem_responder_if b ();

    inst_mem_responder #(.ADDR_W(10), .REQ_LAT(1), .RESP_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .bus(a.slave),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_mem_responder #(.ADDR_W(10), .REQ_LAT(2), .RESP_LAT(1)) dut_b (
        .clk(clk), .rst(rst), .bus(b.slave),
        .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model_mem [0:1023];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_lat(input string name, input int lat, input int base);
        bit ok;
`ifdef INST_RESP_JITTER_EN
        ok = (lat >= base) && (lat <= base + 3);
`else
        ok = (lat == base);
`endif
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: latency %0d cycles, expected base %0d", name, lat, base);
        end
    endtask

    task automatic load_word(input int addr, input logic [31:0] data);
        ld_we   = 1'b1;
        ld_addr = 10'(addr);
        ld_data = data;
        @(negedge clk);
        ld_we = 1'b0;
        model_mem[addr] = data;
    endtask

    // Called at a negedge with dut_a idle; returns data, latency and cycles waited for ready.
    task automatic fetch_a(input logic [31:0] pc, output logic [31:0] data,
                           output int lat, output int waited);
        a.PC = pc;
        a.Inst_Req_Valid = 1'b1;
        a.Inst_Ready = 1'b0;
        waited = 0;
        while (!a.Inst_Req_Ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        a.Inst_Req_Valid = 1'b0;
        a.PC = 32'hFFFF_FFFF;
        lat = 1;
        while (!a.Inst_Valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        data = a.Instruction;
        a.Inst_Ready = 1'b1;
        @(negedge clk);
        a.Inst_Ready = 1'b0;
        chk("valid_drop_after_consume", {31'd0, a.Inst_Valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [31:0] old_w;
        int lat, waited;
        vecs[0] = '{32'h0000_0000, 32'h0000_0013};
        vecs[1] = '{32'h0000_0004, 32'h0010_0093};
        vecs[2] = '{32'h0000_1004, 32'h0010_0093};
        vecs[3] = '{32'h0000_0005, 32'h0010_0093};
        vecs[4] = '{32'h0000_0FFC, 32'hDEAD_BEEF};
        vecs[5] = '{32'hFFFF_FFFF, 32'hDEAD_BEEF};
        vecs[6] = '{32'h0000_0800, 32'hCAFE_F00D};
        vecs[7] = '{32'h0000_0402, 32'h1234_5678};

        rst = 1'b1;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        a.PC = '0; a.Inst_Req_Valid = 1'b0; a.Inst_Ready = 1'b0;
        b.PC = '0; b.Inst_Req_Valid = 1'b0; b.Inst_Ready = 1'b0;
        @(negedge clk);

        // Array is filled while reset is held.
        for (int i = 0; i < 1024; i++)
            load_word(i, (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000);
        load_word(0,    32'h0000_0013);
        load_word(1,    32'h0010_0093);
        load_word(256,  32'h1234_5678);
        load_word(512,  32'hCAFE_F00D);
        load_word(1023, 32'hDEAD_BEEF);

        chk("reset_req_ready", {31'd0, a.Inst_Req_Ready}, 32'd0);
        chk("reset_valid",     {31'd0, a.Inst_Valid},     32'd0);
        chk("reset_instr",     a.Instruction,             32'd0);
        chk("reset_valid_b",   {31'd0, b.Inst_Valid},     32'd0);
        a.Inst_Req_Valid = 1'b1;
        a.PC = 32'h0;
        @(negedge clk);
        chk("reset_ready_held_low", {31'd0, a.Inst_Req_Ready}, 32'd0);
        rst = 1'b0;

`ifndef INST_RESP_JITTER_EN
        // cycle 0: first cycle out of reset, request already held
        chk("t1_c0_ready", {31'd0, a.Inst_Req_Ready}, 32'd0);
        @(negedge clk);
        chk("t1_c1_ready", {31'd0, a.Inst_Req_Ready}, 32'd1);
        @(negedge clk);
        chk("t1_c2_busy_valid", {31'd0, a.Inst_Valid}, 32'd0);
        chk("t1_c2_busy_ready", {31'd0, a.Inst_Req_Ready}, 32'd0);
        @(negedge clk);
        chk("t1_c3_valid", {31'd0, a.Inst_Valid}, 32'd1);
        chk("t1_c3_instr", a.Instruction, 32'h0000_0013);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t2_hold_valid", {31'd0, a.Inst_Valid}, 32'd1);
            chk("t2_hold_instr", a.Instruction, 32'h0000_0013);
            chk("t2_hold_req_ready", {31'd0, a.Inst_Req_Ready}, 32'd0);
        end
        a.Inst_Req_Valid = 1'b0;
        a.Inst_Ready = 1'b1;
        @(negedge clk);
        a.Inst_Ready = 1'b0;
        chk("t2_valid_drop", {31'd0, a.Inst_Valid}, 32'd0);
`else
        a.Inst_Req_Valid = 1'b0;
        @(negedge clk);
`endif

        foreach (vecs[i]) begin
            fetch_a(vecs[i].pc, d, lat, waited);
            chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
            chk_lat($sformatf("vec%0d_lat", i), lat, 2);
            chk($sformatf("vec%0d_wait", i), 32'(waited), 32'd1);
        end

`ifndef INST_RESP_JITTER_EN
        // Same-word write in the read cycle returns old data; a write during RESP is not seen.
        old_w = model_mem[2];
        a.PC = 32'h8; a.Inst_Req_Valid = 1'b1;
        @(negedge clk);
        chk("rbw_ready", {31'd0, a.Inst_Req_Ready}, 32'd1);
        @(negedge clk);
        a.Inst_Req_Valid = 1'b0;
        load_word(2, 32'h1111_2222);
        chk("rbw_valid", {31'd0, a.Inst_Valid}, 32'd1);
        chk("rbw_old_data", a.Instruction, old_w);
        load_word(2, 32'h3333_4444);
        chk("resp_write_held", a.Instruction, old_w);
        a.Inst_Ready = 1'b1;
        @(negedge clk);
        a.Inst_Ready = 1'b0;
        fetch_a(32'h8, d, lat, waited);
        chk("rbw_new_data", d, 32'h3333_4444);
`endif

        // Reset during BUSY discards the pending response.
        a.PC = 32'h4; a.Inst_Req_Valid = 1'b1;
        waited = 0;
        while (!a.Inst_Req_Ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        chk("t5_ready_seen", 32'(waited), 32'd1);
        @(negedge clk);
        a.Inst_Req_Valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk("t5_no_valid", {31'd0, a.Inst_Valid}, 32'd0);
            @(negedge clk);
        end
        fetch_a(32'h0, d, lat, waited);
        chk("t5_after_reset_data", d, 32'h0000_0013);
        chk_lat("t5_after_reset_lat", lat, 2);

        // REQ_LAT=2: a withdrawn request restarts the wait.
        b.PC = 32'h4; b.Inst_Req_Valid = 1'b1;
        chk("t3_c0_ready", {31'd0, b.Inst_Req_Ready}, 32'd0);
        @(negedge clk);
        b.Inst_Req_Valid = 1'b0;
        chk("t3_c1_ready", {31'd0, b.Inst_Req_Ready}, 32'd0);
        @(negedge clk);
        b.Inst_Req_Valid = 1'b1;
        chk("t3_c2_ready", {31'd0, b.Inst_Req_Ready}, 32'd0);
        @(negedge clk);
        chk("t3_c3_ready", {31'd0, b.Inst_Req_Ready}, 32'd0);
        @(negedge clk);
        chk("t3_c4_ready", {31'd0, b.Inst_Req_Ready}, 32'd1);
        @(negedge clk);
        b.Inst_Req_Valid = 1'b0;
        b.PC = 32'hFFFF_FFFF;
        lat = 1;
        while (!b.Inst_Valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk_lat("t3_resp_lat", lat, 1);
        chk("t3_data", b.Instruction, 32'h0010_0093);
        b.Inst_Ready = 1'b1;
        @(negedge clk);
        b.Inst_Ready = 1'b0;
        chk("t3_valid_drop", {31'd0, b.Inst_Valid}, 32'd0);

        begin
`ifdef INST_RESP_JITTER_EN
            bit seen [4];
            for (int k = 0; k < 4; k++) seen[k] = 1'b0;
`endif
            for (int n = 0; n < 200; n++) begin
                logic [31:0] pc;
                pc = $urandom;
                fetch_a(pc, d, lat, waited);
                chk("rand_data", d, model_mem[pc[11:2]]);
                chk_lat("rand_lat", lat, 2);
`ifdef INST_RESP_JITTER_EN
                if (lat >= 2 && lat <= 5) seen[lat-2] = 1'b1;
`endif
            end
`ifdef INST_RESP_JITTER_EN
            chk("jitter_all_latencies_seen", {28'd0, seen[3], seen[2], seen[1], seen[0]}, 32'hF);
`endif
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
